shift_seq_ctrl_32: RTL and testbench
====================================

// Module: shift_seq_ctrl_32
// PURPOSE
//  Command sequencer for the 32-bit 74LS194-chain shift register (shift_reg_32bit).
//  Accepts one shift/rotate command (op, amount, data) via valid/ready handshake.
//  Parallel-loads the data, then steps the chain one bit per clock, amount times.
//  Returns the result on a valid/ready result port; sits between a CPU/ALU front end and the chain.
// PARAMETERS
//  WIDTH  32  datapath width; fixed by shift_reg_32bit, any other value is illegal
//  AMT_W  5   shift-amount width, log2(WIDTH)
// PORTS
//  clk        in   1      rising-edge clock
//  CR         in   1      asynchronous active-low reset (clears FSM, counter, datapath)
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      controller can accept a command (high only in IDLE)
//  cmd_op     in   3      000 SHL, 001 SHR, 010 ROL, 011 ROR, 100 ASR (macro), others pass-through
//  cmd_amt    in   AMT_W  shift count, 0..31
//  cmd_data   in   WIDTH  operand
//  res_valid  out  1      result present (high only in DONE)
//  res_ready  in   1      consumer accepts result
//  res_data   out  WIDTH  chain output Q; stable while res_valid=1
//  busy       out  1      high in LOAD or SHIFT
// BEHAVIOUR
//  Reset (CR=0, async): state=IDLE, cnt=0, latched op/amt=0, Q=0 (chain clear=~CR).
//  Reset outputs: cmd_ready=1, res_valid=0, busy=0, res_data=0.
//  Chain mode encoding {S1,S0}: 00 hold, 01 shift right (Q[31]<-SR), 10 shift left (Q[0]<-SL), 11 load.
//  States:
//   IDLE  : mode 00; cmd_ready=1; on cmd_valid latch op/amt/data -> LOAD.
//   LOAD  : mode 11, PData=latched data; cnt<=amt; -> SHIFT if amt!=0 and op legal, else -> DONE.
//   SHIFT : mode per op, cnt decrements each clock; on the cnt==1 edge -> DONE.
//   DONE  : mode 00; res_valid=1; on res_ready -> IDLE (no command accepted same cycle).
//  Fill bits (combinational from current Q):
//   SHL: mode 10, SL=0.  SHR: mode 01, SR=0.
//   ROL: mode 10, SL=Q[31].  ROR: mode 01, SR=Q[0].  ASR: mode 01, SR=Q[31].
//  Unused fill input is driven 0. Illegal op: treated as amt=0 (result = cmd_data).
//  Latency: accept edge -> res_valid after amt+2 clocks (amt=0: 2 clocks).
//  Backpressure: DONE holds indefinitely with res_data frozen while res_ready=0.
//  cmd_* is sampled only on the accept edge; later changes are ignored.
//  Reset mid-operation: abort immediately, result discarded; no res_valid.
//  Counter is AMT_W bits; it never wraps because amt<=31 and SHIFT exits at cnt==1.
// CONFIGURATION
//  SHIFT_SEQ_ASR_EN defined  : op 100 performs arithmetic right shift (sign fill from Q[31]).
//  SHIFT_SEQ_ASR_EN undefined: op 100 is illegal -> pass-through, 2-clock latency.
// STRUCTURE
//  Shared package: op-code constants (OP_SHL..OP_ASR), mode constants (MODE_HOLD/SR/SL/LOAD),
//   FSM state encodings, WIDTH/AMT_W defaults.
//  Sub-module: a single instance of shift_reg_32bit as the datapath, with clear driven by ~CR.
//  Controller = FSM + down-counter + fill-bit mux.
// TESTING
//  SHL data=0x0000_0001 amt=4 -> res_data=0x0000_0010; res_valid 6 clocks after accept.
//  ROR data=0x8000_0001 amt=1 -> res_data=0xC000_0000; ROL data=0x8000_0001 amt=4 -> 0x0000_0018.
//  SHR data=0xDEAD_BEEF amt=0 -> res_data=0xDEAD_BEEF after 2 clocks; op=111 -> same pass-through.
//  ASR data=0x8000_0000 amt=31 -> 0xFFFF_FFFF with SHIFT_SEQ_ASR_EN; 0x8000_0000 without it.
//  res_ready held low 10 clocks after SHL 0x1 amt=1 -> res_valid=1 and res_data=0x2 stable;
//   cmd_ready=0 throughout; accept resumes the clock after res_ready=1.
//  CR pulsed low during SHIFT (amt=20, cycle 5) -> Q=0, IDLE, cmd_ready=1 async; no res_valid.

Source files
------------

// File: rtl/shift_seq_ctrl_32_pkg.sv
// Shared constants and types for the 32-bit shift/rotate command sequencer.
// Honours SHIFT_SEQ_ASR_EN: when defined, op 100 is an arithmetic right shift.
package shift_seq_ctrl_32_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned AMT_W = 5;

    localparam logic [2:0] OP_SHL = 3'b000;
    localparam logic [2:0] OP_SHR = 3'b001;
    localparam logic [2:0] OP_ROL = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ASR = 3'b100;

    // Chain mode {S1,S0}
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SR   = 2'b01;
    localparam logic [1:0] MODE_SL   = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_LOAD  = 2'b01;
    localparam logic [1:0] ST_SHIFT = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    typedef struct packed {
        logic [2:0]       op;
        logic [AMT_W-1:0] amt;
        logic [WIDTH-1:0] data;
    } cmd_t;

    // Ops that actually step the chain; anything else is a pass-through.
    function automatic logic op_legal(input logic [2:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: ok = 1'b1;
`ifdef SHIFT_SEQ_ASR_EN
            OP_ASR: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/shift_reg_32bit.sv
// 32-bit universal shift register built like a chain of 74LS194s.
// Async active-high clear; mode 00 hold, 01 right, 10 left, 11 load.
module shift_reg_32bit
    import shift_seq_ctrl_32_pkg::*;
(
    input  logic             clk,
    input  logic             clear,
    input  logic [1:0]       s,
    input  logic             sl,
    input  logic             sr,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q <= '0;
        end else begin
            case (s)
                MODE_SR:   q <= {sr, q[WIDTH-1:1]};
                MODE_SL:   q <= {q[WIDTH-2:0], sl};
                MODE_LOAD: q <= pdata;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/shift_seq_ctrl_32.sv
// Command sequencer: loads an operand into the 194 chain and steps it amt times.
// Macro SHIFT_SEQ_ASR_EN enables op 100 (arithmetic right shift); otherwise it passes through.
module shift_seq_ctrl_32
    import shift_seq_ctrl_32_pkg::*;
(
    input  logic             clk,
    input  logic             CR,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    logic [1:0]       state, state_next;
    logic [AMT_W-1:0] cnt, cnt_next;
    cmd_t             cmd, cmd_next;
    logic             cmd_ready_next, res_valid_next, busy_next;
    logic [1:0]       mode_c;
    logic             sl_c, sr_c;
    logic [WIDTH-1:0] q;

    shift_reg_32bit u_chain (
        .clk   (clk),
        .clear (~CR),
        .s     (mode_c),
        .sl    (sl_c),
        .sr    (sr_c),
        .pdata (cmd.data),
        .q     (q)
    );

    assign res_data = q;

    // Chain mode and fill bits, taken from the live Q so rotates wrap correctly
    always_comb begin
        mode_c = MODE_HOLD;
        sl_c   = 1'b0;
        sr_c   = 1'b0;
        case (state)
            ST_LOAD: mode_c = MODE_LOAD;
            ST_SHIFT: begin
                case (cmd.op)
                    OP_SHL: mode_c = MODE_SL;
                    OP_SHR: mode_c = MODE_SR;
                    OP_ROL: begin
                        mode_c = MODE_SL;
                        sl_c   = q[WIDTH-1];
                    end
                    OP_ROR: begin
                        mode_c = MODE_SR;
                        sr_c   = q[0];
                    end
`ifdef SHIFT_SEQ_ASR_EN
                    OP_ASR: begin
                        mode_c = MODE_SR;
                        sr_c   = q[WIDTH-1];
                    end
`endif
                    default: mode_c = MODE_HOLD;
                endcase
            end
            default: mode_c = MODE_HOLD;
        endcase
    end

    // Next-state, counter and registered-output decode
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cmd_next   = cmd;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_next.op   = cmd_op;
                    cmd_next.amt  = cmd_amt;
                    cmd_next.data = cmd_data;
                    state_next    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_next = cmd.amt;
                if ((cmd.amt != '0) && op_legal(cmd.op)) begin
                    state_next = ST_SHIFT;
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_SHIFT: begin
                cnt_next = cnt - AMT_W'(1);
                if (cnt == AMT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        cmd_ready_next = (state_next == ST_IDLE);
        res_valid_next = (state_next == ST_DONE);
        busy_next      = (state_next == ST_LOAD) || (state_next == ST_SHIFT);
    end

    always_ff @(posedge clk or negedge CR) begin
        if (!CR) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cmd       <= '0;
            cmd_ready <= 1'b1;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            cmd       <= cmd_next;
            cmd_ready <= cmd_ready_next;
            res_valid <= res_valid_next;
            busy      <= busy_next;
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl_32.sv
// Self-checking bench for shift_seq_ctrl_32: directed cases plus randomized traffic
// checked every cycle against a latency/result model of the sequencer.
module tb_shift_seq_ctrl_32;
    import shift_seq_ctrl_32_pkg::*;

    logic        clk = 1'b0;
    logic        CR;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_amt;
    logic [31:0] cmd_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    shift_seq_ctrl_32 dut (
        .clk       (clk),
        .CR        (CR),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .cmd_data  (cmd_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit asr_enabled();
`ifdef SHIFT_SEQ_ASR_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit legal(input logic [2:0] op);
        return (op <= 3'd3) || (op == 3'd4 && asr_enabled());
    endfunction

    function automatic int unsigned eff_amt(input logic [2:0] op, input int unsigned amt);
        return legal(op) ? amt : 0;
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] op, input int unsigned amt,
                                               input logic [31:0] d);
        logic [31:0] r;
        r = d;
        if (amt != 0 && legal(op)) begin
            case (op)
                3'd0: r = d << amt;
                3'd1: r = d >> amt;
                3'd2: r = (d << amt) | (d >> (32 - amt));
                3'd3: r = (d >> amt) | (d << (32 - amt));
                3'd4: r = $signed(d) >>> amt;
                default: r = d;
            endcase
        end
        return r;
    endfunction

    // Model: 0 idle, 1 working (m_left edges until done), 2 done
    int          m_phase = 0;
    int          m_left  = 0;
    logic [31:0] m_res   = '0;
    logic [31:0] m_q     = '0;
    bit          m_qk    = 1'b1;

    always @(posedge clk or negedge CR) begin
        if (!CR) begin
            m_phase = 0;
            m_q     = '0;
            m_qk    = 1'b1;
        end else begin
            case (m_phase)
                0: if (cmd_valid) begin
                    m_res   = ref_result(cmd_op, cmd_amt, cmd_data);
                    m_left  = eff_amt(cmd_op, cmd_amt) + 1;
                    m_phase = 1;
                    m_qk    = 1'b0;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_q     = m_res;
                        m_qk    = 1'b1;
                    end
                end
                default: if (res_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("cmd_ready", 32'(cmd_ready), 32'(m_phase == 0));
        check("busy",      32'(busy),      32'(m_phase == 1));
        check("res_valid", 32'(res_valid), 32'(m_phase == 2));
        if (m_qk) check("res_data", res_data, m_q);
    end

    task automatic run_cmd(input logic [2:0] op, input logic [4:0] amt, input logic [31:0] d,
                           input logic [31:0] exp_res, input int exp_lat, input string name);
        int lat;
        check({name, "_ready"}, 32'(cmd_ready), 32'd1);
        res_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = amt;
        cmd_data  = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_amt   = 5'($urandom);
        cmd_data  = $urandom;
        lat = 1;
        while (!res_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_result"}, res_data, exp_res);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        CR        = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_amt   = '0;
        cmd_data  = '0;
        res_ready = 1'b0;

        // Model sanity against hand-computed values
        check("model_shl", ref_result(3'd0, 4, 32'h0000_0001), 32'h0000_0010);
        check("model_ror", ref_result(3'd3, 1, 32'h8000_0001), 32'hC000_0000);
        check("model_rol", ref_result(3'd2, 4, 32'h8000_0001), 32'h0000_0018);
        check("model_asr", ref_result(3'd4, 31, 32'h8000_0000),
              asr_enabled() ? 32'hFFFF_FFFF : 32'h8000_0000);

        #22;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_res_data",  res_data,       32'd0);
        CR = 1'b1;
        @(posedge clk); #1;

        run_cmd(3'd0, 5'd4,  32'h0000_0001, 32'h0000_0010, 6, "shl4");
        run_cmd(3'd3, 5'd1,  32'h8000_0001, 32'hC000_0000, 3, "ror1");
        run_cmd(3'd2, 5'd4,  32'h8000_0001, 32'h0000_0018, 6, "rol4");
        run_cmd(3'd1, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 2, "shr0");
        run_cmd(3'd7, 5'd9,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 2, "op7");
        run_cmd(3'd0, 5'd31, 32'hFFFF_FFFF, 32'h8000_0000, 33, "shl31");
        if (asr_enabled())
            run_cmd(3'd4, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 33, "asr31");
        else
            run_cmd(3'd4, 5'd31, 32'h8000_0000, 32'h8000_0000, 2, "asr31");

        // Backpressure: result frozen and no accept while res_ready is low
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_amt = 5'd1; cmd_data = 32'h1;
        @(posedge clk); #1;
        cmd_op = 3'd0; cmd_amt = 5'd0; cmd_data = 32'h5;
        lat = 0;
        while (!res_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(res_valid), 32'd1);
            check("bp_data",  res_data,       32'h2);
            check("bp_ready", 32'(cmd_ready), 32'd0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("bp_release_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("bp_reaccept_busy", 32'(busy), 32'd1);
        lat = 0;
        while (!res_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check("bp_second_result", res_data, 32'h5);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;

        // Reset in the middle of a long shift
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_amt = 5'd20; cmd_data = 32'hA5A5_0F0F;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("mid_busy", 32'(busy), 32'd1);
        CR = 1'b0;
        #1;
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_res_data",  res_data,       32'd0);
        @(posedge clk); #3;
        CR = 1'b1;
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (res_valid) lat++;
        end
        check("abort_no_result", 32'(lat), 32'd0);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_op    = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       cmd_amt = 5'd0;
                1:       cmd_amt = 5'd31;
                default: cmd_amt = 5'($urandom);
            endcase
            cmd_data  = $urandom;
            res_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                CR = 1'b0;
                #2;
                CR = 1'b1;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        repeat (40) begin @(posedge clk); #1; end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
